// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: registered payload+valid between two pipeline stages.
// Handles the shared stall vector, flush, bubble insertion on an upstream-only
// stall, a scratch loop back to the producing stage for multi-cycle ops, and
// saturating stall/bubble counters.
//
// action  | condition (priority order)      | effect
// reset   | rst_n = 1 (active high)         | clear payload, scratch, counters
// flush   | flush = 1                       | payload -> NOP, scratch -> 0
// bubble  | up_stop & !dn_stop              | payload -> NOP, scratch loops, bubble_count++
// advance | !up_stop                        | payload <- input, scratch -> 0
// hold    | up_stop & dn_stop               | payload kept, scratch loops, stall_cycles++
module pipe_stage_reg #(
  parameter int                DATA_W    = 32,
  parameter int                SCRATCH_W = 66,
  parameter int                STALL_W   = 6,
  parameter int                STAGE     = 3,
  parameter logic [DATA_W-1:0] NOP_VAL   = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [SCRATCH_W-1:0] scratch_i,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [SCRATCH_W-1:0] scratch_o,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     bubble_count
);

  if (STAGE >= STALL_W || STAGE < 0 || DATA_W < 1 || SCRATCH_W < 1) begin : g_param_check
    $error("pipe_stage_reg: STAGE must be in 0..STALL_W-1 and widths must be >= 1");
  end

  // The stall vector is padded with a zero on top so the top stage sees no
  // downstream stall without needing a separate generate branch.
  logic [STALL_W:0] stall_ext;
  logic             up_stop;
  logic             dn_stop;

  assign stall_ext = {1'b0, stall};
  assign up_stop   = stall_ext[STAGE];
  assign dn_stop   = stall_ext[STAGE+1];

  // Payload, valid and scratch loop update, one action per cycle by priority.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VAL;
      scratch_o <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VAL;
      scratch_o <= '0;
    end else if (up_stop && !dn_stop) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VAL;
      scratch_o <= scratch_i;
    end else if (!up_stop) begin
      // Also taken for the illegal up=0/dn=1 pattern: the stage still advances.
      out_valid <= in_valid;
      out_data  <= in_data;
      scratch_o <= '0;
    end else begin
      scratch_o <= scratch_i;
    end
  end

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_cycles <= '0;
      bubble_count <= '0;
    end else if (!flush && up_stop) begin
      if (dn_stop) begin
        if (stall_cycles != {CNT_W{1'b1}}) stall_cycles <= stall_cycles + 1'b1;
      end else begin
        if (bubble_count != {CNT_W{1'b1}}) bubble_count <= bubble_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: one task per scenario with inline checks.
module tb_pipe_stage_reg;

  localparam int          DW  = 32;
  localparam int          SW  = 66;
  localparam int          STW = 6;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [STW-1:0] stall;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [SW-1:0] scratch_i;

  logic          out_valid, out_valid5;
  logic [DW-1:0] out_data, out_data5;
  logic [SW-1:0] scratch_o, scratch_o5;
  logic [3:0]    stall_cycles, bubble_count;
  logic [15:0]   stall_cycles5, bubble_count5;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .SCRATCH_W(SW), .STALL_W(STW), .STAGE(3),
                   .NOP_VAL(NOP), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .scratch_i(scratch_i),
    .out_valid(out_valid), .out_data(out_data), .scratch_o(scratch_o),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count)
  );

  pipe_stage_reg #(.DATA_W(DW), .SCRATCH_W(SW), .STALL_W(STW), .STAGE(5),
                   .NOP_VAL(NOP), .CNT_W(16)) u_top (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .scratch_i(scratch_i),
    .out_valid(out_valid5), .out_data(out_data5), .scratch_o(scratch_o5),
    .stall_cycles(stall_cycles5), .bubble_count(bubble_count5)
  );

  // The stall controller never stops stage 4 without also stopping stage 3.
  always @(posedge clk) begin
    if (!rst_n && !flush) begin
      assert (!(!stall[3] && stall[4]))
        else $error("illegal stall pattern %b for STAGE=3", stall);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; flush = 1'b0; stall = '0;
    step();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0; stall = '0;
    in_valid = 1'b1; in_data = 32'h1111_1111; scratch_i = 66'd5;
    step(); step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== NOP) begin tests_failed++; $display("FAIL reset_data: got %h want %h", out_data, NOP); end
    tests_run++;
    if (scratch_o !== 66'd0) begin tests_failed++; $display("FAIL reset_scratch: got %h want 0", scratch_o); end
    tests_run++;
    if (stall_cycles !== 4'd0 || bubble_count !== 4'd0) begin
      tests_failed++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, bubble_count);
    end
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL advance: got %b/%h want 1/deadbeef", out_valid, out_data);
    end
  endtask

  task automatic test_bubble();
    stall = 6'b001111;
    for (int i = 1; i <= 3; i++) begin
      scratch_i = 66'(i);
      step();
      tests_run++;
      if (out_valid !== 1'b0 || out_data !== NOP) begin
        tests_failed++; $display("FAIL bubble_payload[%0d]: got %b/%h want 0/%h", i, out_valid, out_data, NOP);
      end
      tests_run++;
      if (scratch_o !== 66'(i)) begin
        tests_failed++; $display("FAIL bubble_scratch[%0d]: got %0d want %0d", i, scratch_o, i);
      end
    end
    tests_run++;
    if (bubble_count !== 4'd3 || stall_cycles !== 4'd0) begin
      tests_failed++; $display("FAIL bubble_count: got %0d/%0d want 3/0", bubble_count, stall_cycles);
    end
  endtask

  task automatic test_hold();
    stall = '0; in_valid = 1'b1; in_data = 32'h1234_5678; scratch_i = 66'd99;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || scratch_o !== 66'd0) begin
      tests_failed++; $display("FAIL hold_load: got %b/%h/%0d want 1/12345678/0", out_valid, out_data, scratch_o);
    end
    stall = 6'b011111; in_data = 32'h0BAD_0BAD; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scratch_i = 66'(10 + i);
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
        tests_failed++; $display("FAIL hold_payload[%0d]: got %b/%h want 1/12345678", i, out_valid, out_data);
      end
      tests_run++;
      if (scratch_o !== 66'(10 + i) || stall_cycles !== 4'(i + 1)) begin
        tests_failed++; $display("FAIL hold_scratch_cnt[%0d]: got %0d/%0d want %0d/%0d", i, scratch_o, stall_cycles, 10 + i, i + 1);
      end
    end
    tests_run++;
    if (bubble_count !== 4'd3) begin tests_failed++; $display("FAIL hold_bubble_unchanged: got %0d want 3", bubble_count); end
  endtask

  task automatic test_flush();
    stall = '0; in_valid = 1'b1; in_data = 32'hAAAA_5555;
    step();
    stall = 6'b011111; scratch_i = 66'h3_0000_0000_0000_0007;
    step();
    tests_run++;
    if (out_data !== 32'hAAAA_5555 || scratch_o !== 66'h3_0000_0000_0000_0007 || stall_cycles !== 4'd5) begin
      tests_failed++; $display("FAIL flush_setup: got %h/%h/%0d want aaaa5555/30000000000000007/5", out_data, scratch_o, stall_cycles);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== NOP || scratch_o !== 66'd0) begin
      tests_failed++; $display("FAIL flush_priority: got %b/%h/%0d want 0/%h/0", out_valid, out_data, scratch_o, NOP);
    end
    tests_run++;
    if (stall_cycles !== 4'd5 || bubble_count !== 4'd3) begin
      tests_failed++; $display("FAIL flush_counters: got %0d/%0d want 5/3", stall_cycles, bubble_count);
    end
    stall = 6'b001111; flush = 1'b1;
    step();
    flush = 1'b0;
    tests_run++;
    if (bubble_count !== 4'd3 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_over_bubble: got %0d/%b want 3/0", bubble_count, out_valid);
    end
    stall = '0; flush = 1'b1; rst_n = 1'b1;
    step();
    rst_n = 1'b0; flush = 1'b0;
    tests_run++;
    if (stall_cycles !== 4'd0 || bubble_count !== 4'd0) begin
      tests_failed++; $display("FAIL flush_with_reset: got %0d/%0d want 0/0", stall_cycles, bubble_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    stall = '0; in_valid = 1'b1; in_data = 32'h5555_AAAA;
    step();
    stall = 6'b011111; scratch_i = 66'd42;
    step(); step();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== NOP || scratch_o !== 66'd0 || stall_cycles !== 4'd0) begin
      tests_failed++; $display("FAIL reset_mid_stall: got %b/%h/%0d/%0d want 0/%h/0/0", out_valid, out_data, scratch_o, stall_cycles, NOP);
    end
    stall = '0; in_data = 32'h0000_00AB;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_00AB || scratch_o !== 66'd0) begin
      tests_failed++; $display("FAIL after_reset_advance: got %b/%h/%0d want 1/000000ab/0", out_valid, out_data, scratch_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    stall = 6'b001111;
    for (int i = 1; i <= 20; i++) begin
      step();
      tests_run++;
      if (bubble_count !== 4'((i > 15) ? 15 : i)) begin
        tests_failed++; $display("FAIL saturation[%0d]: got %0d want %0d", i, bubble_count, (i > 15) ? 15 : i);
      end
    end
  endtask

  task automatic test_top_stage();
    do_reset();
    in_valid = 1'b1; in_data = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      stall = (i < 2) ? 6'b100000 : 6'b111111;
      scratch_i = 66'(100 + i);
      step();
      tests_run++;
      if (out_valid5 !== 1'b0 || out_data5 !== NOP || scratch_o5 !== 66'(100 + i)) begin
        tests_failed++; $display("FAIL top_bubble[%0d]: got %b/%h/%0d want 0/%h/%0d", i, out_valid5, out_data5, scratch_o5, NOP, 100 + i);
      end
      tests_run++;
      if (bubble_count5 !== 16'(i + 1) || stall_cycles5 !== 16'd0) begin
        tests_failed++; $display("FAIL top_counters[%0d]: got %0d/%0d want %0d/0", i, bubble_count5, stall_cycles5, i + 1);
      end
    end
    stall = '0;
    step();
    tests_run++;
    if (out_valid5 !== 1'b1 || out_data5 !== 32'hCAFE_F00D || scratch_o5 !== 66'd0) begin
      tests_failed++; $display("FAIL top_advance: got %b/%h/%0d want 1/cafef00d/0", out_valid5, out_data5, scratch_o5);
    end
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; stall = '0;
    in_valid = 1'b0; in_data = '0; scratch_i = '0;
    #2;
    test_reset();
    test_bubble();
    test_hold();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_top_stage();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register, the generalised successor of the EX/MEM latch. It carries an arbitrary-width payload with a valid bit between two pipeline stages, honours the shared stall vector and a flush, and inserts a NOP bubble when its upstream stage stalls but its downstream stage does not. It loops multi-cycle-operation scratch state back to the producing stage while held, and keeps saturating stall and bubble counters for performance monitoring.

## Interface
- DATA_W, 32: payload width in bits; minimum 1.
- SCRATCH_W, 66: width of the multi-cycle scratch loop, for example a 64-bit hi/lo accumulator plus a 2-bit cycle count; minimum 1.
- STALL_W, 6: width of the global stall vector.
- STAGE, 3: index of this register's upstream stage in the stall vector; valid range is 0..STALL_W-1.
- NOP_VAL, {DATA_W{1'b0}}: payload value driven during reset, flush and bubble.
- CNT_W, 16: width of the performance counters.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: reset. Synchronous and active-high, per the codebase `RstEnable polarity.
- stall, in, STALL_W: global stall vector; 1 means stop.
- flush, in, 1: kills the payload currently in flight; intended for exception and branch redirects.
- in_valid, in, 1: the upstream payload is a real instruction.
- in_data, in, DATA_W: upstream payload.
- scratch_i, in, SCRATCH_W: partial result from the multi-cycle unit in the upstream stage.
- out_valid, out, 1: the registered payload is real.
- out_data, out, DATA_W: registered payload.
- scratch_o, out, SCRATCH_W: scratch state returned to the upstream stage.
- stall_cycles, out, CNT_W: count of cycles in which the register held.
- bubble_count, out, CNT_W: count of inserted bubbles.

## Operation
Definitions:
- up_stop = stall[STAGE].
- dn_stop = stall[STAGE+1]. When STAGE = STALL_W-1, dn_stop is the constant 0.

Exactly one action is taken per cycle, chosen by the following priority (highest first):
1. Reset (rst_n = 1):
   - out_valid = 0, out_data = NOP_VAL, scratch_o = 0.
   - stall_cycles = 0, bubble_count = 0.
2. Flush (flush = 1):
   - out_valid = 0, out_data = NOP_VAL, scratch_o = 0.
   - Counters unchanged.
   - Flush overrides every stall combination.
3. Bubble (up_stop = 1 and dn_stop = 0):
   - out_valid = 0, out_data = NOP_VAL.
   - scratch_o = scratch_i; the multi-cycle operation keeps iterating.
   - bubble_count increments.
4. Advance (up_stop = 0):
   - out_valid = in_valid, out_data = in_data.
   - scratch_o = 0; the operation has completed and its result has left with the payload.
5. Hold (up_stop = 1 and dn_stop = 1):
   - out_valid and out_data keep their values.
   - scratch_o = scratch_i.
   - stall_cycles increments.

Further rules:
- Counters saturate at 2^CNT_W-1; they never wrap.
- The counters are not cleared by advance or flush; only reset clears them.
- The combination up_stop = 0 with dn_stop = 1 is illegal, because the stall controller sets every upstream bit as well. If it occurs, the advance action applies; the bench flags it with an assertion but the RTL still advances.
- The elaboration-time check fails if STAGE ≥ STALL_W or if DATA_W < 1.
- No combinational path exists from any input to any output; all outputs are registered.

## Timing
- Latency is 1 cycle: in_data sampled at edge N appears on out_data after edge N.
- A bubble inserted at edge N is visible for the following cycle.
- Consecutive bubbles repeat for as long as the stall pattern persists.
- scratch_o follows scratch_i with 1-cycle delay while the register is stalled (bubble or hold). The upstream unit therefore sees its own previous-cycle result.
- When an advance follows a stall, scratch_o reads 0 in the cycle after the advance edge.
- Reset mid-stall: the next edge clears everything, including the counters and the scratch loop. The stall state is not remembered.
- When flush and rst_n are asserted in the same cycle, the reset action applies and the counters clear.
- When a flush arrives during a multi-cycle operation, the scratch loop is discarded (scratch_o = 0 after the edge).

## Test plan
1. Reset and advance:
   - Stimulus: rst_n = 1 for 2 cycles, then in_valid = 1, in_data = 0xDEADBEEF, stall = 0.
   - Required: during reset all outputs are 0 / NOP_VAL. One edge after release, out_valid = 1 and out_data = 0xDEADBEEF.
2. Bubble insertion and scratch loop:
   - Stimulus: STAGE = 3, stall = 6'b001111 for 3 cycles, scratch_i = 1, 2, 3 on successive cycles.
   - Required: out_valid = 0 and out_data = NOP_VAL for all 3 cycles; scratch_o = 1, 2, 3 with 1-cycle lag; bubble_count = 3.
3. Hold:
   - Stimulus: load 0x12345678, then stall = 6'b011111 for 4 cycles.
   - Required: out_data remains 0x12345678 with out_valid = 1; stall_cycles = 4; bubble_count unchanged.
4. Flush priority:
   - Stimulus: flush = 1 while stall = 6'b011111 and out_data = 0xAAAA5555.
   - Required: the next cycle shows out_valid = 0, out_data = NOP_VAL, scratch_o = 0.
5. Counter saturation:
   - Stimulus: CNT_W = 4, 20 consecutive bubble cycles.
   - Required: bubble_count stops at 15 and does not wrap.
6. Top-stage boundary:
   - Stimulus: STAGE = 5, STALL_W = 6, stall[5] = 1.
   - Required: a bubble every cycle (dn_stop is treated as 0).
   - Stimulus: stall[5] = 0.
   - Required: advance with a 1-cycle delay.
